imuldiv_muldiv_arb: RTL and testbench
=====================================

# imuldiv_muldiv_arb

Two-port arbiter that shares one `imuldiv` multiply/divide unit between two requesters, such as two pipelines or a pipeline and an accelerator. Each requester issues `MulDivReqMsg` requests on a val/rdy port. The block grants requests round-robin, forwards them to the single unit, and tracks issue order in a tag queue. Responses from the unit are returned to the requester that issued them, in order.

## Interface
Parameters:
- `DEPTH`, default 4: maximum outstanding requests; must be a power of two, at least 2.
- `RESP_SZ`, default 64: response message width, `{hi, lo}` result.

Ports:
- `clk` input 1: clock. Single clock domain; reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high reset.
- `req0_val` / `req0_rdy` in/out 1: requester 0 request handshake.
- `req0_msg` in `IMULDIV_MULDIVREQ_MSG_SZ` (67): `{func[2:0], a[31:0], b[31:0]}`.
- `req1_val` / `req1_rdy` / `req1_msg`: requester 1, same as port 0.
- `resp0_val` / `resp0_rdy` out/in 1: response handshake to requester 0.
- `resp0_msg` out `RESP_SZ`: response to requester 0.
- `resp1_val` / `resp1_rdy` / `resp1_msg`: response to requester 1, same as port 0.
- `unit_req_val` / `unit_req_rdy` out/in 1: request handshake to the muldiv unit.
- `unit_req_msg` out 67: request to the muldiv unit.
- `unit_resp_val` / `unit_resp_rdy` in/out 1: response handshake from the muldiv unit.
- `unit_resp_msg` in `RESP_SZ`: response from the muldiv unit.

## Operation
- A transfer fires when `val && rdy` are both high at a `clk` edge.
- Arbitration is combinational over `req0_val` and `req1_val`.
  - If only one is valid, that one wins.
  - If both are valid, the winner is the requester not granted last. Register `last` resets to 1, so requester 0 wins first.
- `unit_req_val = (req0_val | req1_val) & !full`.
- `unit_req_msg` = the winner's message, bit-exact.
- `reqN_rdy = winN & unit_req_rdy & !full`. The loser's `rdy` is 0.
- On request fire:
  - push the winner ID (1 bit) into the tag queue;
  - set `last` to the winner.
  - `last` is unchanged when no request fires.
- Tag queue: `DEPTH` entries, circular read/write pointers, occupancy count of width `$clog2(DEPTH)+1`.
  - Pointers wrap modulo `DEPTH`.
  - `full` is `count == DEPTH`; `empty` is `count == 0`.
- Response routing: the head tag `h` selects the destination port.
  - `respH_val = unit_resp_val & !empty`; the other port's `resp_val` is 0.
  - `respN_msg = unit_resp_msg` on both ports; only the `val`ed port is meaningful.
  - `unit_resp_rdy = !empty & respH_rdy`.
- On response fire, pop the tag queue.
- Simultaneous push and pop:
  - When not full, both occur and `count` is unchanged.
  - When full, push is blocked by `!full` even if a pop fires in the same cycle. No bypass.
- `unit_resp_val` while `empty` is a protocol error. It is ignored and never acknowledged.
- The `func` field is not decoded. Mul, div, divu, rem and remu are all handled identically.

## Timing
- Request path: zero added latency. The unit sees the request in the same cycle it is offered.
- Response path: zero added latency, combinational routing.
- Unit latency is opaque. The block only requires the unit to return responses in order.
- Reset, in any cycle including mid-operation:
  - pointers and `count` return to 0, `last` returns to 1;
  - while `reset` is high, all `rdy` and `val` outputs are forced to 0;
  - outstanding tags are discarded. The muldiv unit must be reset in the same cycle.
- Throughput: one request and one response per cycle when unstalled.
- At most `DEPTH` requests are outstanding.

## Configuration
- `IMULDIV_MULDIV_ARB_FIXED_PRIO_EN`:
  - **Defined:** fixed priority; requester 0 always wins ties and `last` is not instantiated.
  - **Undefined (default):** round-robin as in Operation.
- Ports and routing are identical in both builds.

## Structure
- Shared header `imuldiv-MulDivArbMsg.v` holds:
  - `IMULDIV_MULDIVRESP_MSG_SZ` (64);
  - tag width (1);
  - requester ID constants `IMULDIV_ARB_REQ0`/`REQ1`.
- Request field macros come from the existing `MulDivReqMsg` header.
- Sub-module `imuldiv_muldiv_arb_tagq`:
  - parameterised 1-bit-wide, `DEPTH`-entry FIFO;
  - ports `enq_val`, `deq_val`, `full`, `empty`, `head`.
- The top level holds the arbiter, `last`, and the routing muxes.

## Test plan
- **Single requester:** req0 sends `{mul, 18, 68}`; unit model returns 1224 after 3 cycles → `unit_req_msg` matches bit-exact; `resp0_val` with 1224; `resp1_val` never asserts.
- **Round-robin:** both requesters hold `val` continuously with `{div, 42, 1}` and `{rem, 42, 1}` → grants alternate 0,1,0,1…; resp0 gets 42, resp1 gets 0, in issue order.
- **Full:** unit never returns and `unit_req_rdy = 1`; 4 requests issued → the 5th sees `reqN_rdy = 0`; one response pop → `rdy` stays 0 that cycle and rises the next.
- **Backpressure:** `resp1_rdy = 0` while head tag = 1 → `unit_resp_rdy = 0` and the queue holds; `resp1_rdy = 1` → pop, and the next head routes correctly.
- **Reset mid-operation:** 3 requests outstanding, `reset` high for 1 cycle → `count = 0`, all `val`/`rdy` outputs 0 during reset; the first post-reset tie grants requester 0.
- **Fixed priority (macro defined):** both `val` held for 4 cycles → all 4 grants go to requester 0; req1 is granted only after req0 drops.

Source files
------------

// File: rtl/imuldiv_muldiv_arb_pkg.sv
// Shared message sizes, requester IDs and request layout for the muldiv arbiter.
// Constants only; no logic or timing.
package imuldiv_muldiv_arb_pkg;

   localparam int IMULDIV_MULDIVREQ_MSG_SZ  = 67;
   localparam int IMULDIV_MULDIVRESP_MSG_SZ = 64;
   localparam int IMULDIV_ARB_TAG_SZ        = 1;

   localparam logic IMULDIV_ARB_REQ0 = 1'b0;
   localparam logic IMULDIV_ARB_REQ1 = 1'b1;

   typedef enum logic [2:0] {
      MULDIV_MUL  = 3'd0,
      MULDIV_DIV  = 3'd1,
      MULDIV_DIVU = 3'd2,
      MULDIV_REM  = 3'd3,
      MULDIV_REMU = 3'd4
   } muldiv_func_e;

   typedef struct packed {
      logic [2:0]  func;
      logic [31:0] a;
      logic [31:0] b;
   } muldiv_req_t;

endpackage

// File: rtl/imuldiv_muldiv_arb_tagq.sv
// Tag queue: DEPTH-entry, 1-bit-wide circular FIFO of requester IDs in issue order.
// Latency: enqueued tag is visible at head one cycle after enqueue when empty.
// Backpressure: enq ignored while full, deq ignored while empty; no full bypass.
module imuldiv_muldiv_arb_tagq #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enq_val,
   input  logic enq_tag,
   input  logic deq_val,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];

   logic [DEPTH-1:0] tags;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_enq;
   logic             do_deq;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign head   = tags[rd_ptr];
   assign do_enq = enq_val & !full;
   assign do_deq = deq_val & !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) begin
            tags[wr_ptr] <= enq_tag;
            wr_ptr       <= wr_ptr + PTR_ONE;
         end
         if (do_deq) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_enq, do_deq})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imuldiv_muldiv_arb.sv
// Shares one muldiv unit between two requesters; round-robin, or fixed priority with IMULDIV_MULDIV_ARB_FIXED_PRIO_EN.
// Latency: zero added cycles on both request and response paths (combinational grant and routing).
// Backpressure: requests stall while DEPTH tags are outstanding; responses stall on the owning port's resp_rdy.
module imuldiv_muldiv_arb
   import imuldiv_muldiv_arb_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int RESP_SZ = IMULDIV_MULDIVRESP_MSG_SZ
) (
   input  logic                                clk,
   input  logic                                reset,

   input  logic                                req0_val,
   output logic                                req0_rdy,
   input  logic [IMULDIV_MULDIVREQ_MSG_SZ-1:0] req0_msg,

   input  logic                                req1_val,
   output logic                                req1_rdy,
   input  logic [IMULDIV_MULDIVREQ_MSG_SZ-1:0] req1_msg,

   output logic                                resp0_val,
   input  logic                                resp0_rdy,
   output logic [RESP_SZ-1:0]                  resp0_msg,

   output logic                                resp1_val,
   input  logic                                resp1_rdy,
   output logic [RESP_SZ-1:0]                  resp1_msg,

   output logic                                unit_req_val,
   input  logic                                unit_req_rdy,
   output logic [IMULDIV_MULDIVREQ_MSG_SZ-1:0] unit_req_msg,

   input  logic                                unit_resp_val,
   output logic                                unit_resp_rdy,
   input  logic [RESP_SZ-1:0]                  unit_resp_msg
);

   logic win0;
   logic win1;
   logic full;
   logic empty;
   logic head;
   logic req_fire;
   logic resp_fire;

`ifdef IMULDIV_MULDIV_ARB_FIXED_PRIO_EN
   assign win0 = req0_val;
   assign win1 = req1_val & !req0_val;
`else
   logic last;

   // On a tie the requester not granted last wins; reset favours requester 0.
   assign win0 = req0_val & (!req1_val | (last == IMULDIV_ARB_REQ1));
   assign win1 = req1_val & (!req0_val | (last == IMULDIV_ARB_REQ0));

   always_ff @(posedge clk) begin
      if (reset) begin
         last <= IMULDIV_ARB_REQ1;
      end else if (req_fire) begin
         last <= win1;
      end
   end
`endif

   assign unit_req_val = (req0_val | req1_val) & !full & !reset;
   assign unit_req_msg = win1 ? req1_msg : req0_msg;
   assign req0_rdy     = win0 & unit_req_rdy & !full & !reset;
   assign req1_rdy     = win1 & unit_req_rdy & !full & !reset;
   assign req_fire     = unit_req_val & unit_req_rdy;

   // A response with no outstanding tag is a protocol error and is never acknowledged.
   assign resp0_val     = unit_resp_val & !empty & (head == IMULDIV_ARB_REQ0) & !reset;
   assign resp1_val     = unit_resp_val & !empty & (head == IMULDIV_ARB_REQ1) & !reset;
   assign resp0_msg     = unit_resp_msg;
   assign resp1_msg     = unit_resp_msg;
   assign unit_resp_rdy = !empty & (head ? resp1_rdy : resp0_rdy) & !reset;
   assign resp_fire     = unit_resp_val & unit_resp_rdy;

   imuldiv_muldiv_arb_tagq #(
      .DEPTH (DEPTH)
   ) tagq (
      .clk     (clk),
      .reset   (reset),
      .enq_val (req_fire),
      .enq_tag (win1),
      .deq_val (resp_fire),
      .full    (full),
      .empty   (empty),
      .head    (head)
   );

endmodule

// File: tb/tb_imuldiv_muldiv_arb.sv
// Randomized bench with a queue-based reference of the arbiter and an in-order muldiv unit model.
module tb_imuldiv_muldiv_arb;
   import imuldiv_muldiv_arb_pkg::*;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        req0_val, req0_rdy, req1_val, req1_rdy;
   logic [66:0] req0_msg, req1_msg, unit_req_msg;
   logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic [63:0] resp0_msg, resp1_msg, unit_resp_msg;
   logic        unit_req_val, unit_req_rdy, unit_resp_val, unit_resp_rdy;

   imuldiv_muldiv_arb #(.DEPTH(DEPTH), .RESP_SZ(64)) dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
      .unit_req_val(unit_req_val), .unit_req_rdy(unit_req_rdy), .unit_req_msg(unit_req_msg),
      .unit_resp_val(unit_resp_val), .unit_resp_rdy(unit_resp_rdy), .unit_resp_msg(unit_resp_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      int          due;
   } uentry_t;

   uentry_t     uq[$];
   logic [63:0] exp0[$];
   logic [63:0] exp1[$];
   bit          tagm[$];
   int          grant_log[$];
   int          last_m = 1;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ufires = 0;
   bit          f0 = 0, f1 = 0;
   bit          watch_grant = 0;
   int          post_rst_grant = -1;

   int p0 = 0, p1 = 0, urdy_pct = 100, r0_pct = 100, r1_pct = 100;
   int msg_mode = 0, fixed_delay = -1;
   bit stall = 0, spurious = 0;

   bit m_full, m_empty, m_head;
   int m_win, m_due;
   bit e_uval, e_r0, e_r1, e_v0, e_v1, e_urdy;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [66:0] gen_msg(input int port);
      muldiv_req_t m;
      if (msg_mode == 1) begin
         m.func = MULDIV_MUL; m.a = 32'd18; m.b = 32'd68;
      end else if (msg_mode == 2) begin
         m.func = (port == 0) ? MULDIV_DIV : MULDIV_REM; m.a = 32'd42; m.b = 32'd1;
      end else begin
         m.func = 3'($urandom_range(4));
         m.a    = $urandom;
         m.b    = $urandom;
         if ($urandom_range(3) == 0) begin
            m.a = $urandom_range(200);
            m.b = $urandom_range(20, 1);
         end
         if (m.b == 32'd0) m.b = 32'd1;
      end
      return m;
   endfunction

   // What a correct muldiv unit returns: full product, or zero-extended quotient/remainder.
   function automatic logic [63:0] ref_result(input logic [66:0] raw);
      muldiv_req_t m;
      longint      sa, sb, r;
      logic [63:0] ua, ub, u;
      m  = raw;
      sa = longint'($signed(m.a));
      sb = longint'($signed(m.b));
      ua = {32'd0, m.a};
      ub = {32'd0, m.b};
      if (m.func != 3'd0 && m.b == 32'd0) return 64'd0;
      case (m.func)
         3'd0: begin r = sa * sb; return r; end
         3'd1: begin r = sa / sb; return {32'd0, r[31:0]}; end
         3'd2: begin u = ua / ub; return {32'd0, u[31:0]}; end
         3'd3: begin r = sa % sb; return {32'd0, r[31:0]}; end
         3'd4: begin u = ua % ub; return {32'd0, u[31:0]}; end
         default: return 64'd0;
      endcase
   endfunction

   // Protocol checker and reference model, evaluated mid-cycle while inputs are stable.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         chk("reset_outputs", {req0_rdy, req1_rdy, resp0_val, resp1_val, unit_req_val, unit_resp_rdy}, 6'd0);
         tagm.delete(); uq.delete(); exp0.delete(); exp1.delete();
         last_m = 1; f0 = 0; f1 = 0;
      end else begin
         m_full  = (tagm.size() == DEPTH);
         m_empty = (tagm.size() == 0);
         m_head  = m_empty ? 1'b0 : tagm[0];
         if (req0_val && req1_val) begin
`ifdef IMULDIV_MULDIV_ARB_FIXED_PRIO_EN
            m_win = 0;
`else
            m_win = (last_m == 1) ? 0 : 1;
`endif
         end else begin
            m_win = req1_val ? 1 : 0;
         end
         e_uval = (req0_val || req1_val) && !m_full;
         e_r0   = req0_val && m_win == 0 && unit_req_rdy && !m_full;
         e_r1   = req1_val && m_win == 1 && unit_req_rdy && !m_full;
         chk("req_handshake", {unit_req_val, req0_rdy, req1_rdy}, {e_uval, e_r0, e_r1});
         if (req0_val || req1_val)
            chk("unit_req_msg", unit_req_msg, (m_win == 1) ? req1_msg : req0_msg);

         e_v0   = unit_resp_val && !m_empty && !m_head;
         e_v1   = unit_resp_val && !m_empty && m_head;
         e_urdy = !m_empty && (m_head ? resp1_rdy : resp0_rdy);
         chk("resp_handshake", {resp0_val, resp1_val, unit_resp_rdy}, {e_v0, e_v1, e_urdy});
         if (unit_resp_val)
            chk("resp_msg_pass", {resp0_msg, resp1_msg}, {unit_resp_msg, unit_resp_msg});

         f0 = req0_val && req0_rdy;
         f1 = req1_val && req1_rdy;
         if (f0) exp0.push_back(ref_result(req0_msg));
         if (f1) exp1.push_back(ref_result(req1_msg));

         if (unit_resp_val && unit_resp_rdy) begin
            if (tagm.size() > 0) void'(tagm.pop_front());
            if (uq.size() > 0) void'(uq.pop_front());
         end
         if (unit_req_val && unit_req_rdy) begin
            ufires++;
            grant_log.push_back(req1_rdy ? 1 : 0);
            if (watch_grant) begin
               post_rst_grant = req1_rdy ? 1 : 0;
               watch_grant    = 0;
            end
            tagm.push_back(m_win[0]);
            last_m = m_win;
            m_due  = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(4, 1)));
            if (uq.size() > 0 && uq[uq.size()-1].due > m_due) m_due = uq[uq.size()-1].due;
            uq.push_back('{res: ref_result(unit_req_msg), due: m_due});
         end
      end
   end

   // Scoreboard monitor: every delivered response must match the oldest expected one for that port.
   always @(negedge clk) begin
      if (!reset) begin
         if (resp0_val && resp0_rdy) begin
            if (exp0.size() == 0) chk("resp0_unexpected", 1, 0);
            else chk("resp0_data", resp0_msg, exp0.pop_front());
         end
         if (resp1_val && resp1_rdy) begin
            if (exp1.size() == 0) chk("resp1_unexpected", 1, 0);
            else chk("resp1_data", resp1_msg, exp1.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (!(req0_val && !f0)) begin
         req0_val = ($urandom_range(99) < p0);
         req0_msg = gen_msg(0);
      end
      if (!(req1_val && !f1)) begin
         req1_val = ($urandom_range(99) < p1);
         req1_msg = gen_msg(1);
      end
      unit_req_rdy = ($urandom_range(99) < urdy_pct);
      resp0_rdy    = ($urandom_range(99) < r0_pct);
      resp1_rdy    = ($urandom_range(99) < r1_pct);
      if (!stall && uq.size() > 0 && uq[0].due <= cyc) begin
         unit_resp_val = 1'b1;
         unit_resp_msg = uq[0].res;
      end else if (spurious && uq.size() == 0 && $urandom_range(7) == 0) begin
         unit_resp_val = 1'b1;
         unit_resp_msg = {$urandom, $urandom};
      end else begin
         unit_resp_val = 1'b0;
         unit_resp_msg = {$urandom, $urandom};
      end
   endtask

   task automatic drain(input string name);
      int n;
      p0 = 0; p1 = 0; stall = 0; spurious = 0;
      urdy_pct = 100; r0_pct = 100; r1_pct = 100;
      n = 0;
      while (n < 300 && (tagm.size() != 0 || exp0.size() != 0 || exp1.size() != 0 || req0_val || req1_val)) begin
         step();
         n++;
      end
      chk(name, (n < 300) ? 1 : 0, 1);
   endtask

   initial begin
      int st, n, start_fires;
      reset = 1'b1;
      req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
      resp0_rdy = 0; resp1_rdy = 0; unit_req_rdy = 0;
      unit_resp_val = 1'b1; unit_resp_msg = '0;
      repeat (3) step();
      reset = 1'b0;

      // Single requester, fixed 3-cycle unit latency, mul 18*68.
      msg_mode = 1; fixed_delay = 3; p0 = 100;
      step();
      p0 = 0;
      drain("single_drain");

      // Both requesters held continuously: grants alternate, starting with 1 since 0 went last.
      msg_mode = 2; fixed_delay = -1; p0 = 100; p1 = 100;
      st = grant_log.size();
      n = 0;
      while (n < 100 && grant_log.size() < st + 8) begin step(); n++; end
      chk("rr_timeout", (grant_log.size() >= st + 8) ? 1 : 0, 1);
      for (int i = 0; i < 8; i++) begin
         if (st + i < grant_log.size()) begin
`ifdef IMULDIV_MULDIV_ARB_FIXED_PRIO_EN
            chk("prio_grant", grant_log[st+i], 0);
`else
            chk("rr_grant", grant_log[st+i], (i + 1) % 2);
`endif
         end
      end
      drain("rr_drain");

      // Unit never returns: exactly DEPTH requests are accepted.
      msg_mode = 0; stall = 1; p0 = 100; p1 = 100; urdy_pct = 100;
      start_fires = ufires;
      repeat (10) step();
      chk("full_accepts", ufires - start_fires, DEPTH);
      drain("full_drain");

      // Requester 1 stalls its response port.
      p0 = 60; p1 = 60; r1_pct = 0;
      repeat (30) step();
      drain("bp_drain");

      // Reset with three requests outstanding; first tie afterwards must go to requester 0.
      stall = 1; p0 = 100; p1 = 0;
      n = 0;
      while (n < 20 && tagm.size() < 3) begin step(); n++; end
      chk("rst_setup", tagm.size(), 3);
      p0 = 0; req0_val = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      stall = 0;
      p0 = 100; p1 = 100;
      watch_grant = 1;
      step();
      n = 0;
      while (n < 20 && post_rst_grant < 0) begin step(); n++; end
      chk("post_reset_first_grant", post_rst_grant, 0);
      drain("rst_drain");

      // Long random run with protocol-error responses sprinkled in while idle.
      spurious = 1;
      for (int e = 0; e < 30; e++) begin
         p0 = $urandom_range(95, 10); p1 = $urandom_range(95, 10);
         urdy_pct = $urandom_range(100, 50);
         r0_pct = $urandom_range(100, 40); r1_pct = $urandom_range(100, 40);
         stall = ($urandom_range(5) == 0);
         repeat (100) step();
      end
      drain("random_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
